// File: rtl/timer_apb_regs.sv
// APB3 register block for one 8-bit timer core.
// It holds the reload value (TDR), the control register (TCR) and the
// sticky status flags (TSR). It also forwards the live count (TCNT) to
// software. The LOAD trigger becomes a one-cycle registered pulse.
module timer_apb_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        tcnt_i,
  input  logic              ovf_i,
  input  logic              udf_i,
  output logic              tmr_load,
  output logic [7:0]        tmr_data,
  output logic              tmr_en,
  output logic              tmr_up_dw,
  output logic [1:0]        tmr_cks,
  output logic              irq
);

  localparam logic [1:0] OFS_TDR  = 2'd0;
  localparam logic [1:0] OFS_TCR  = 2'd1;
  localparam logic [1:0] OFS_TSR  = 2'd2;
  localparam logic [1:0] OFS_TCNT = 2'd3;

  // TCR storage mask: LOAD (bit4) and bit7 are never stored.
  localparam logic [7:0] TCR_MASK = 8'h6F;

  logic [7:0] r_tdr;
  logic [7:0] r_tcr;
  logic       r_ovf;
  logic       r_udf;
  logic       r_lost;
  logic       r_load;

  logic       w_access;
  logic       w_bad_addr;
  logic       w_wr_ok;
  logic       w_rd_ok;
  logic       w_wr_tdr;
  logic       w_wr_tcr;
  logic       w_wr_tsr;
  logic       w_clr_ovf;
  logic       w_clr_udf;
  logic       w_clr_lost;
  logic       w_lost_evt;
  logic [7:0] w_rd_byte;
  logic       w_unused_bits;

  assign w_access   = psel & penable;
  assign w_bad_addr = |paddr[ADDR_W-1:4];
  assign w_wr_ok    = w_access & pwrite & ~w_bad_addr;
  assign w_rd_ok    = w_access & ~pwrite & ~w_bad_addr;

  assign w_wr_tdr = w_wr_ok & (paddr[3:2] == OFS_TDR);
  assign w_wr_tcr = w_wr_ok & (paddr[3:2] == OFS_TCR);
  assign w_wr_tsr = w_wr_ok & (paddr[3:2] == OFS_TSR);

  assign w_clr_ovf  = w_wr_tsr & pwdata[0];
  assign w_clr_udf  = w_wr_tsr & pwdata[1];
  assign w_clr_lost = w_wr_tsr & pwdata[2];

  // A repeat event counts as lost only if software is not acknowledging
  // the same flag on that edge.
  assign w_lost_evt = (ovf_i & r_ovf & ~w_clr_ovf) | (udf_i & r_udf & ~w_clr_udf);

  assign w_unused_bits = ^{paddr[1:0], pwdata[DATA_W-1:8]};

  // Reload value and control fields; LOAD is turned into a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdr  <= 8'h00;
      r_tcr  <= 8'h00;
      r_load <= 1'b0;
    end else begin
      if (w_wr_tdr) r_tdr <= pwdata[7:0];
      if (w_wr_tcr) r_tcr <= pwdata[7:0] & TCR_MASK;
      r_load <= w_wr_tcr & pwdata[4];
    end
  end

  // Sticky status flags: a hardware set beats a W1C clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_ovf  <= ovf_i | (r_ovf & ~w_clr_ovf);
      r_udf  <= udf_i | (r_udf & ~w_clr_udf);
      r_lost <= w_lost_evt | (r_lost & ~w_clr_lost);
    end
  end

  // Read mux; everything reads zero outside a valid read access.
  always_comb begin
    w_rd_byte = 8'h00;
    if (w_rd_ok) begin
      case (paddr[3:2])
        OFS_TDR:  w_rd_byte = r_tdr;
        OFS_TCR:  w_rd_byte = r_tcr;
        OFS_TSR:  w_rd_byte = {5'b00000, r_lost, r_udf, r_ovf};
        OFS_TCNT: w_rd_byte = tcnt_i;
        default:  w_rd_byte = 8'h00;
      endcase
    end
  end

  assign prdata  = {{(DATA_W-8){1'b0}}, w_rd_byte};
  assign pready  = 1'b1;
  assign pslverr = w_access & w_bad_addr;

  assign tmr_load  = r_load;
  assign tmr_data  = r_tdr;
  assign tmr_en    = r_tcr[0];
  assign tmr_up_dw = r_tcr[1];
  assign tmr_cks   = r_tcr[3:2];

  assign irq = (r_ovf & r_tcr[5]) | (r_udf & r_tcr[6]);

endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: a vector table for plain
// register accesses, plus hand sequences for LOAD, flags and reset.
module tb_timer_apb_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tcnt_i;
  logic        ovf_i, udf_i;
  logic        tmr_load;
  logic [7:0]  tmr_data;
  logic        tmr_en, tmr_up_dw;
  logic [1:0]  tmr_cks;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  timer_apb_regs #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .tcnt_i(tcnt_i), .ovf_i(ovf_i), .udf_i(udf_i),
    .tmr_load(tmr_load), .tmr_data(tmr_data), .tmr_en(tmr_en),
    .tmr_up_dw(tmr_up_dw), .tmr_cks(tmr_cks), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                           input logic exp_err, input string nm,
                           input logic udf_in_access = 1'b0);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    udf_i = udf_in_access;
    #1;
    chk({nm, "_err"}, {31'd0, pslverr}, {31'd0, exp_err});
    chk({nm, "_rdy"}, {31'd0, pready}, 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; udf_i = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp_d,
                          input logic exp_err, input string nm);
    exp_t e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    e.rdata = exp_d;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_data"}, prdata, e.rdata);
      chk({nm, "_err"}, {31'd0, pslverr}, {31'd0, e.err});
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr)
        apb_write(vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, $sformatf("vec%0d_wr", i));
      else
        apb_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d_rd", i));
    end
    vecs.delete();
  endtask

  function automatic void add_vec(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input logic err);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rdata = rd; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  task automatic pulse(input logic is_ovf);
    @(negedge clk);
    if (is_ovf) ovf_i = 1'b1; else udf_i = 1'b1;
    @(negedge clk);
    ovf_i = 1'b0; udf_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 32'h0; tcnt_i = 8'h5A; ovf_i = 1'b0; udf_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {21'd0, tmr_load, tmr_data, tmr_en, tmr_up_dw, tmr_cks, irq}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd1);
    rst_n = 1'b1;

    // Reset readback and TDR programming.
    add_vec(1'b0, 8'h00, 32'h0, 32'h00, 1'b0);
    add_vec(1'b0, 8'h04, 32'h0, 32'h00, 1'b0);
    add_vec(1'b0, 8'h08, 32'h0, 32'h00, 1'b0);
    add_vec(1'b0, 8'h0C, 32'h0, 32'h5A, 1'b0);
    add_vec(1'b1, 8'h00, 32'hFFFF_FFC8, 32'h0, 1'b0);
    add_vec(1'b0, 8'h00, 32'h0, 32'hC8, 1'b0);
    run_vecs();

    // TCR with LOAD: controls and one-cycle load pulse.
    apb_write(8'h04, 32'h1D, 1'b0, "tcr_load");
    chk("load_hi", {31'd0, tmr_load}, 32'd1);
    chk("tmr_ctl", {20'd0, tmr_data, tmr_en, tmr_up_dw, tmr_cks}, {20'd0, 8'hC8, 1'b1, 1'b0, 2'b11});
    @(posedge clk); #1;
    chk("load_lo", {31'd0, tmr_load}, 32'd0);

    // Back-to-back LOAD writes give back-to-back pulses.
    apb_write(8'h04, 32'h1D, 1'b0, "tcr_load2");
    chk("load2_hi", {31'd0, tmr_load}, 32'd1);

    // Readbacks, unmapped addresses and ignored TCNT write.
    add_vec(1'b0, 8'h04, 32'h0, 32'h0D, 1'b0);
    add_vec(1'b1, 8'h10, 32'h55, 32'h0, 1'b1);
    add_vec(1'b0, 8'h10, 32'h0, 32'h00, 1'b1);
    add_vec(1'b0, 8'h00, 32'h0, 32'hC8, 1'b0);
    add_vec(1'b0, 8'h04, 32'h0, 32'h0D, 1'b0);
    add_vec(1'b0, 8'h08, 32'h0, 32'h00, 1'b0);
    add_vec(1'b1, 8'h0C, 32'h33, 32'h0, 1'b0);
    add_vec(1'b0, 8'h0C, 32'h0, 32'h5A, 1'b0);
    add_vec(1'b1, 8'hF4, 32'h00, 32'h0, 1'b1);
    add_vec(1'b0, 8'h06, 32'h0, 32'h0D, 1'b0);
    run_vecs();
    chk("after_err_tmr", {22'd0, tmr_data, tmr_en, tmr_cks}, {22'd0, 8'hC8, 1'b1, 2'b11});

    // OVF capture, LOST and W1C.
    apb_write(8'h04, 32'h20, 1'b0, "tcr_ovfie");
    chk("irq_pre_ovf", {31'd0, irq}, 32'd0);
    pulse(1'b1);
    chk("irq_ovf", {31'd0, irq}, 32'd1);
    apb_read(8'h08, 32'h01, 1'b0, "tsr_ovf");
    pulse(1'b1);
    apb_read(8'h08, 32'h05, 1'b0, "tsr_lost");
    apb_write(8'h08, 32'h01, 1'b0, "w1c_ovf");
    chk("irq_clr", {31'd0, irq}, 32'd0);
    apb_read(8'h08, 32'h04, 1'b0, "tsr_lostonly");
    apb_write(8'h08, 32'h04, 1'b0, "w1c_lost");
    apb_read(8'h08, 32'h00, 1'b0, "tsr_clear");

    // UDF: set wins against simultaneous clear, no LOST.
    apb_write(8'h04, 32'h40, 1'b0, "tcr_udfie");
    pulse(1'b0);
    chk("irq_udf", {31'd0, irq}, 32'd1);
    apb_write(8'h08, 32'h02, 1'b0, "w1c_udf_race", 1'b1);
    chk("irq_race", {31'd0, irq}, 32'd1);
    apb_read(8'h08, 32'h02, 1'b0, "tsr_race");
    apb_write(8'h04, 32'h00, 1'b0, "tcr_ie_off");
    chk("irq_ie_off", {31'd0, irq}, 32'd0);
    apb_read(8'h08, 32'h02, 1'b0, "tsr_kept");

    // Reset during the LOAD pulse.
    apb_write(8'h04, 32'h11, 1'b0, "tcr_load_rst");
    chk("load_rst_hi", {31'd0, tmr_load}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("load_rst_lo", {30'd0, tmr_load, tmr_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    add_vec(1'b0, 8'h00, 32'h0, 32'h00, 1'b0);
    add_vec(1'b0, 8'h04, 32'h0, 32'h00, 1'b0);
    add_vec(1'b0, 8'h08, 32'h0, 32'h00, 1'b0);
    run_vecs();
    chk("post_rst_outs", {21'd0, tmr_load, tmr_data, tmr_en, tmr_up_dw, tmr_cks, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
